// File: rtl/noc_input_buffer.sv
// noc_input_buffer
// Per-input-port flit buffer of the NoC router. Single-flit packets are
// stored in a circular FIFO. The head flit is routed with dimension-order
// XY routing and presented to the output arbiter as a one-hot request.
// Each granted pop returns one credit to the upstream router.
//
// Handshake semantics (the only ones used in this block):
//   push : accepted on a rising edge when flit_valid_in=1 and either the
//          FIFO is not full or a pop happens on the same edge. A push into
//          a full FIFO with no pop is dropped and sets the sticky overflow.
//   pop  : happens on a rising edge when gnt_in=1 and empty=0. gnt_in
//          while empty is ignored.
//   credit_out pulses for one cycle after every pop edge.
// All outputs are functions of registered state only.
module noc_input_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        flit_in,
    input  logic                     flit_valid_in,
    output logic                     credit_out,
    output logic [4:0]               req_out,
    output logic [DATA_W-1:0]        flit_out,
    input  logic                     gnt_in,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [X_W-1:0]   MY_X_C  = X_W'(MY_X);
    localparam logic [Y_W-1:0]   MY_Y_C  = Y_W'(MY_Y);

    // One-hot request bit positions.
    localparam int REQ_N = 0;
    localparam int REQ_S = 1;
    localparam int REQ_E = 2;
    localparam int REQ_W = 3;
    localparam int REQ_L = 4;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_en;
    logic              pop_en;
    logic [DATA_W-1:0] head;
    logic [X_W-1:0]    dest_x;
    logic [Y_W-1:0]    dest_y;

    // Status flags derived from the registered occupancy.
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // A pop frees a slot on the same edge, so a push into a full FIFO
    // is accepted when it coincides with a pop.
    assign pop_en  = gnt_in & ~empty;
    assign push_en = flit_valid_in & (~full | pop_en);

    // Flit storage; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= flit_in;
        end
    end

    // Pointers, occupancy, credit pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            credit_out <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            credit_out <= pop_en;
            if (flit_valid_in && full && !pop_en) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head flit and its destination fields.
    assign head     = mem[rd_ptr];
    assign flit_out = empty ? '0 : head;
    assign dest_x   = head[DATA_W-1 -: X_W];
    assign dest_y   = head[DATA_W-1-X_W -: Y_W];

    // XY route of the head flit: X dimension first, then Y, else local.
    always_comb begin
        req_out = '0;
        if (!empty) begin
            if (dest_x > MY_X_C) begin
                req_out[REQ_E] = 1'b1;
            end else if (dest_x < MY_X_C) begin
                req_out[REQ_W] = 1'b1;
            end else if (dest_y > MY_Y_C) begin
                req_out[REQ_N] = 1'b1;
            end else if (dest_y < MY_Y_C) begin
                req_out[REQ_S] = 1'b1;
            end else begin
                req_out[REQ_L] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// tb_noc_input_buffer
// Bench for noc_input_buffer at DEPTH=4, MY_X=1, MY_Y=1. The driver issues
// push/grant cycles and keeps the reference FIFO contents in exp_q; the
// monitor samples on the falling edge, checks status/route/head/credit and
// pops exp_q whenever a grant meets a non-empty FIFO.
module tb_noc_input_buffer;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] flit_in;
    logic              flit_valid_in;
    logic              credit_out;
    logic [4:0]        req_out;
    logic [DATA_W-1:0] flit_out;
    logic              gnt_in;
    logic [2:0]        count;
    logic              full;
    logic              empty;
    logic              overflow;

    logic [DATA_W-1:0] exp_q[$];
    logic              m_ovf;
    logic              pop_pending;
    int                n_total;
    int                n_bad;

    noc_input_buffer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_valid_in(flit_valid_in),
        .credit_out(credit_out), .req_out(req_out), .flit_out(flit_out),
        .gnt_in(gnt_in), .count(count), .full(full), .empty(empty),
        .overflow(overflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Expected request for a flit at router (1,1), from the XY rules.
    function automatic logic [4:0] route(logic [DATA_W-1:0] f);
        int dx;
        int dy;
        dx = int'(f[31:30]);
        dy = int'(f[29:28]);
        if (dx > 1)      return 5'b00100;
        else if (dx < 1) return 5'b01000;
        else if (dy > 1) return 5'b00001;
        else if (dy < 1) return 5'b00010;
        else             return 5'b10000;
    endfunction

    function automatic logic [DATA_W-1:0] mk(int dx, int dy);
        logic [27:0] pl;
        pl = 28'($urandom);
        return {2'(dx), 2'(dy), pl};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1; drives one cycle and updates the model at the edge.
    // The monitor has already removed a granted head at the preceding
    // falling edge, so a full FIFO with a grant has room here.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic g);
        flit_valid_in = v;
        flit_in       = d;
        gnt_in        = g;
        @(posedge clk);
        if (v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        flit_valid_in = 1'b0;
        gnt_in        = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_req", 32'(req_out), 0);
        chk("rst_flit_out", flit_out, 0);
        chk("rst_credit", 32'(credit_out), 0);
        chk("rst_overflow", 32'(overflow), 0);
        exp_q.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    // Falling-edge monitor: status, head, route and credit against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            pop_pending <= 1'b0;
        end else begin
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(exp_q.size() == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("credit", 32'(credit_out), 32'(pop_pending));
            if (exp_q.size() > 0) begin
                chk("flit_out", flit_out, exp_q[0]);
                chk("req_out", 32'(req_out), 32'(route(exp_q[0])));
            end else begin
                chk("req_idle", 32'(req_out), 0);
            end
            if (gnt_in && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pop_pending <= 1'b1;
            end else begin
                pop_pending <= 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int dests[5][2];
        n_total       = 0;
        n_bad         = 0;
        m_ovf         = 1'b0;
        pop_pending   = 1'b0;
        rst_n         = 1'b0;
        flit_in       = '0;
        flit_valid_in = 1'b0;
        gnt_in        = 1'b0;
        #22;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Route check: E, W, N, S, Local, each pushed alone then popped.
        dests = '{'{2, 1}, '{0, 3}, '{1, 3}, '{1, 0}, '{1, 1}};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, mk(dests[i][0], dests[i][1]), 1'b0);
            step(1'b0, '0, 1'b1);
            idle(1);
        end

        // Fill then drain with continuous grant.
        for (int i = 0; i < 4; i++) step(1'b1, mk(i, 3 - i), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        idle(2);

        // Push while full without grant: dropped, overflow sticky.
        for (int i = 0; i < 4; i++) step(1'b1, mk(3 - i, i), 1'b0);
        step(1'b1, mk(2, 2), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        idle(1);

        // Push while full with grant: accepted, F drains last.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, mk(i, i), 1'b0);
        step(1'b1, mk(0, 0), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        idle(1);

        // Simultaneous push/pop at occupancy 2 across pointer wrap.
        for (int i = 0; i < 2; i++) step(1'b1, mk(1, 2), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, mk(i % 4, (i + 1) % 4), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        idle(1);

        // Reset mid-operation with 3 flits stored; no credits afterwards.
        for (int i = 0; i < 3; i++) step(1'b1, mk(2, i), 1'b0);
        do_reset();
        idle(3);

        // Randomized traffic, including occasional overflow.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 32'($urandom), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
